// File: rtl/mem_io_responder_pkg.sv
// Address map, byte-bus width and address decode shared by the mem_io_responder slice.
package mem_io_responder_pkg;

    localparam int BYTE_W     = 8;
    localparam int DEC_AW     = 18;
    localparam int RAM_AW_DEF = 17;

    localparam logic [DEC_AW-1:0] IO_BASE      = 18'h30000;
    localparam logic [DEC_AW-1:0] IO_DATA_ADDR = 18'h30000;
    localparam logic [DEC_AW-1:0] IO_CLK_ADDR  = 18'h30004;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_RX,
        SEL_CNT
    } sel_e;

    // 0x30004..0x30007 share one select; the byte lane comes from a[1:0].
    function automatic sel_e decode(input logic [DEC_AW-1:0] a);
        if (!a[DEC_AW-1]) return SEL_RAM;
        if (a[DEC_AW-1:DEC_AW-2] != IO_BASE[DEC_AW-1:DEC_AW-2]) return SEL_NONE;
        if (a == IO_DATA_ADDR) return SEL_RX;
        if (a[DEC_AW-1:2] == IO_CLK_ADDR[DEC_AW-1:2]) return SEL_CNT;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through head; used as the TX queue.
module mem_io_responder_byte_fifo
    import mem_io_responder_pkg::*;
#(
    parameter int W          = BYTE_W,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [W-1:0]      push_data,
    input  logic              pop,
    output logic [W-1:0]      head,
    output logic              full,
    output logic              empty,
    output logic [DEPTH_LOG2:0] count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [W-1:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty = (count == '0);

    no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
    no_pop_when_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/mem_io_responder.sv
// CPU byte-bus responder: 128KB RAM, RX/TX byte ports, cycle counter, program-stop flag.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int    RAM_AW        = RAM_AW_DEF,
    parameter int    TX_DEPTH_LOG2 = 4,
    parameter string RAM_INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cpu_a_i,
    input  logic [BYTE_W-1:0] cpu_wdata_i,
    input  logic              cpu_wr_i,
    output logic [BYTE_W-1:0] cpu_rdata_o,
    output logic              cpu_rdy_o,
    input  logic              rx_valid_i,
    input  logic [BYTE_W-1:0] rx_data_i,
    output logic              rx_ready_o,
    output logic              tx_valid_o,
    output logic [BYTE_W-1:0] tx_data_o,
    input  logic              tx_ready_i,
    output logic              prog_done_o
);

    localparam int            TX_DEPTH  = 1 << TX_DEPTH_LOG2;
    localparam int            CW        = TX_DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] RDY_LIMIT = CW'(TX_DEPTH - 1);
    localparam string         unused_init_file = RAM_INIT_FILE;

    logic [DEC_AW-1:0] a_p0;
    sel_e              sel_p0;
    sel_e              sel_p1;
    logic              rd_p0;
    logic              wr_p0;
    logic [BYTE_W-1:0] ram [2**RAM_AW];
    logic [BYTE_W-1:0] ram_q_p1;
    logic [BYTE_W-1:0] io_q_p1;
    logic [31:0]       cycle_cnt;
    logic [31:0]       snap;
    logic              push;
    logic              pop;
    logic [BYTE_W-1:0] push_data;
    logic              tx_full;
    logic              tx_empty;
    logic [CW-1:0]     tx_count;
    logic [CW-1:0]     tx_count_next;
    logic              unused_addr_hi;

    function automatic logic [BYTE_W-1:0] snap_byte(input logic [31:0] s, input logic [1:0] idx);
        return s[{idx, 3'b000} +: BYTE_W];
    endfunction

    // Stage p0: decode the bus; nothing is accepted while rdy is low.
    assign a_p0           = cpu_a_i[DEC_AW-1:0];
    assign unused_addr_hi = ^cpu_a_i[31:DEC_AW];
    assign sel_p0         = decode(a_p0);
    assign rd_p0          = cpu_rdy_o && !cpu_wr_i;
    assign wr_p0          = cpu_rdy_o && cpu_wr_i;

    assign rx_ready_o = !rst && rd_p0 && (sel_p0 == SEL_RX) && rx_valid_i;

    assign push = wr_p0 && (((a_p0 == IO_DATA_ADDR) && (cpu_wdata_i != '0)) || (a_p0 == IO_CLK_ADDR));
    assign push_data     = (a_p0 == IO_CLK_ADDR) ? '0 : cpu_wdata_i;
    assign pop           = !tx_empty && tx_ready_i;
    assign tx_count_next = tx_count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (wr_p0 && sel_p0 == SEL_RAM) ram[a_p0[RAM_AW-1:0]] <= cpu_wdata_i;
        if (rd_p0 && sel_p0 == SEL_RAM) ram_q_p1 <= ram[a_p0[RAM_AW-1:0]];
    end

    // Reading byte 0 returns the live count and freezes it for bytes 1..3.
    always_ff @(posedge clk) begin
        if (rd_p0) begin
            case (sel_p0)
                SEL_RX:  io_q_p1 <= rx_valid_i ? rx_data_i : '0;
                SEL_CNT: io_q_p1 <= (a_p0[1:0] == 2'd0) ? cycle_cnt[BYTE_W-1:0]
                                                        : snap_byte(snap, a_p0[1:0]);
                default: io_q_p1 <= '0;
            endcase
        end
    end

    // Rdy drops one slot early so a push issued in the cycle it falls still fits.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            snap        <= '0;
            sel_p1      <= SEL_NONE;
            prog_done_o <= 1'b0;
            cpu_rdy_o   <= 1'b1;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            cpu_rdy_o <= (tx_count_next < RDY_LIMIT);
            if (cpu_rdy_o) sel_p1 <= rd_p0 ? sel_p0 : SEL_NONE;
            if (rd_p0 && sel_p0 == SEL_CNT && a_p0[1:0] == 2'd0) snap <= cycle_cnt;
            if (wr_p0 && a_p0 == IO_CLK_ADDR) prog_done_o <= 1'b1;
        end
    end

    // Stage p1: steer the registered read byte back to the CPU.
    always_comb begin
        cpu_rdata_o = '0;
        case (sel_p1)
            SEL_RAM:         cpu_rdata_o = ram_q_p1;
            SEL_RX, SEL_CNT: cpu_rdata_o = io_q_p1;
            default:         cpu_rdata_o = '0;
        endcase
    end

    mem_io_responder_byte_fifo #(
        .W          (BYTE_W),
        .DEPTH_LOG2 (TX_DEPTH_LOG2)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (tx_data_o),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    assign tx_valid_o = !tx_empty;

    tx_never_overflows: assert property (@(posedge clk) disable iff (rst) !(push && tx_full));

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: vector table for decode plus hand sequences for TX, counter, reset.
module tb_mem_io_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_a_i;
    logic [7:0]  cpu_wdata_i;
    logic        cpu_wr_i;
    logic [7:0]  cpu_rdata_o;
    logic        cpu_rdy_o;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        prog_done_o;

    int          nvec = 0;
    int          nfail = 0;
    logic [31:0] tb_cnt;
    logic [7:0]  txq[$];

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  wd;
        logic        rxv;
        logic [7:0]  rxd;
        logic        chk;
        logic [7:0]  exp_rd;
        logic        exp_rxr;
    } vec_t;

    vec_t vt[17];

    mem_io_responder dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_a_i     (cpu_a_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_wr_i    (cpu_wr_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_rdy_o   (cpu_rdy_o),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .rx_ready_o  (rx_ready_o),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .tx_ready_i  (tx_ready_i),
        .prog_done_o (prog_done_o)
    );

    always #5 clk = ~clk;

    // Free-running count of edges since reset, used only to time the counter reads.
    always @(posedge clk) tb_cnt <= rst ? 32'd0 : tb_cnt + 32'd1;

    always @(negedge clk) begin
        if (tx_valid_o === 1'b1 && tx_ready_i === 1'b1) txq.push_back(tx_data_o);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 1000000", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] wd);
        cpu_a_i     = a;
        cpu_wr_i    = wr;
        cpu_wdata_i = wd;
    endtask

    task automatic idle();
        drive(32'h0002_0000, 1'b0, 8'h00);
    endtask

    initial begin
        vt[0]  = '{32'h0001_0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[1]  = '{32'h0001_0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0};
        vt[2]  = '{32'h0001_FFFF, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[3]  = '{32'h0001_FFFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0};
        vt[4]  = '{32'h0000_0000, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[5]  = '{32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0};
        vt[6]  = '{32'h0000_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0};
        vt[7]  = '{32'h0002_0000, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[8]  = '{32'h0002_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
        vt[9]  = '{32'hFFFC_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0};
        vt[10] = '{32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 8'h41, 1'b1};
        vt[11] = '{32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h55, 1'b1, 8'h00, 1'b0};
        vt[12] = '{32'h0003_0000, 1'b1, 8'h00, 1'b1, 8'h42, 1'b0, 8'h00, 1'b0};
        vt[13] = '{32'h0003_0010, 1'b0, 8'h00, 1'b1, 8'h43, 1'b1, 8'h00, 1'b0};
        vt[14] = '{32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'h44, 1'b1, 8'hA5, 1'b0};
        vt[15] = '{32'h0003_FFFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
        vt[16] = '{32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h45, 1'b1, 8'h00, 1'b0};

        rst        = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        tx_ready_i = 1'b0;
        idle();
        cyc();
        cyc();
        cyc();
        check("reset_rdata", cpu_rdata_o, 8'h00);
        check("reset_rdy", cpu_rdy_o, 1'b1);
        check("reset_rx_ready", rx_ready_o, 1'b0);
        check("reset_tx_valid", tx_valid_o, 1'b0);
        check("reset_prog_done", prog_done_o, 1'b0);
        rst = 1'b0;

        // Decode table: RAM, unmapped, RX port, other I/O.
        for (int i = 0; i < 17; i++) begin
            drive(vt[i].a, vt[i].wr, vt[i].wd);
            rx_valid_i = vt[i].rxv;
            rx_data_i  = vt[i].rxd;
            #1;
            check($sformatf("vec%0d_rx_ready", i), rx_ready_o, vt[i].exp_rxr);
            cyc();
            if (vt[i].chk) check($sformatf("vec%0d_rdata", i), cpu_rdata_o, vt[i].exp_rd);
        end
        rx_valid_i = 1'b0;
        idle();

        // 'H','i',0x00 -> only two bytes leave.
        tx_ready_i = 1'b1;
        txq.delete();
        drive(32'h0003_0000, 1'b1, 8'h48); cyc();
        drive(32'h0003_0000, 1'b1, 8'h69); cyc();
        drive(32'h0003_0000, 1'b1, 8'h00); cyc();
        idle();
        for (int k = 0; k < 6; k++) cyc();
        check("hi_count", txq.size(), 2);
        if (txq.size() == 2) begin
            check("hi_byte0", txq[0], 8'h48);
            check("hi_byte1", txq[1], 8'h69);
        end

        // Backpressure: 15 pushes fill to depth-1, rdy falls, then drains in order.
        tx_ready_i = 1'b0;
        txq.delete();
        for (int i = 1; i <= 15; i++) begin
            drive(32'h0003_0000, 1'b1, 8'(i));
            #1;
            check($sformatf("bp_rdy_before_push%0d", i), cpu_rdy_o, 1'b1);
            cyc();
        end
        check("bp_rdy_after_15", cpu_rdy_o, 1'b0);
        check("bp_tx_valid", tx_valid_o, 1'b1);
        drive(32'h0003_0000, 1'b1, 8'd16);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check($sformatf("bp_rdy_held%0d", k), cpu_rdy_o, 1'b0);
        end
        idle();
        tx_ready_i = 1'b1;
        for (int k = 0; k < 40 && txq.size() < 15; k++) cyc();
        for (int k = 0; k < 4; k++) cyc();
        check("bp_drain_count", txq.size(), 15);
        for (int i = 0; i < 15 && i < txq.size(); i++)
            check($sformatf("bp_drain_byte%0d", i), txq[i], 8'(i + 1));
        check("bp_rdy_restored", cpu_rdy_o, 1'b1);

        // Program stop emits a 0x00 byte and raises the sticky flag.
        txq.delete();
        drive(32'h0003_0004, 1'b1, 8'h99);
        cyc();
        check("prog_done_set", prog_done_o, 1'b1);
        idle();
        for (int k = 0; k < 3; k++) cyc();
        check("prog_done_sticky", prog_done_o, 1'b1);
        check("prog_done_tx_count", txq.size(), 1);
        if (txq.size() == 1) check("prog_done_tx_byte", txq[0], 8'h00);

        // Reset in the middle of a write burst, with a RAM read pending.
        tx_ready_i = 1'b0;
        drive(32'h0003_0000, 1'b1, 8'h21); cyc();
        drive(32'h0003_0000, 1'b1, 8'h22); cyc();
        drive(32'h0003_0000, 1'b1, 8'h23); cyc();
        check("burst_tx_valid", tx_valid_o, 1'b1);
        rst = 1'b1;
        drive(32'h0003_0000, 1'b1, 8'h24); cyc();
        drive(32'h0000_0010, 1'b0, 8'h00); cyc();
        check("rst_rdata_dropped", cpu_rdata_o, 8'h00);
        check("rst_tx_valid", tx_valid_o, 1'b0);
        check("rst_prog_done", prog_done_o, 1'b0);
        check("rst_rdy", cpu_rdy_o, 1'b1);
        idle();
        rst = 1'b0;
        tx_ready_i = 1'b1;
        cyc();
        check("post_rst_tx_valid", tx_valid_o, 1'b0);

        // Cycle counter: 300 cycles after reset, then a read straddling 0x1FF -> 0x200.
        for (int k = 0; k < 1000 && tb_cnt != 32'd300; k++) cyc();
        if (tb_cnt != 32'd300) begin
            nvec++;
            nfail++;
            $display("FAIL cnt300_wait: reached %0d, required 300", tb_cnt);
        end
        drive(32'h0003_0004, 1'b0, 8'h00); cyc();
        check("cnt300_b0", cpu_rdata_o, 8'h2C);
        drive(32'h0003_0005, 1'b0, 8'h00); cyc();
        check("cnt300_b1", cpu_rdata_o, 8'h01);
        drive(32'h0003_0006, 1'b0, 8'h00); cyc();
        check("cnt300_b2", cpu_rdata_o, 8'h00);
        drive(32'h0003_0007, 1'b0, 8'h00); cyc();
        check("cnt300_b3", cpu_rdata_o, 8'h00);
        idle();
        for (int k = 0; k < 1000 && tb_cnt != 32'h1FF; k++) cyc();
        if (tb_cnt != 32'h1FF) begin
            nvec++;
            nfail++;
            $display("FAIL cnt1ff_wait: reached %0d, required 511", tb_cnt);
        end
        drive(32'h0003_0004, 1'b0, 8'h00); cyc();
        check("cnt1ff_b0", cpu_rdata_o, 8'hFF);
        drive(32'h0003_0005, 1'b0, 8'h00); cyc();
        check("cnt1ff_b1_coherent", cpu_rdata_o, 8'h01);
        drive(32'h0003_0006, 1'b0, 8'h00); cyc();
        check("cnt1ff_b2", cpu_rdata_o, 8'h00);
        idle();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
